// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing controller.
// VIDEO_TIMING_POLARITY_EN widens the config address to reach the sync polarity field.
package video_timing_pkg;

    localparam int unsigned CounterBits = 12;
    localparam int unsigned TotalBits   = CounterBits + 2;

`ifdef VIDEO_TIMING_POLARITY_EN
    localparam int unsigned CfgAddrBits = 4;
`else
    localparam int unsigned CfgAddrBits = 3;
`endif

    localparam logic [CfgAddrBits-1:0] AddrHsync   = CfgAddrBits'(0);
    localparam logic [CfgAddrBits-1:0] AddrHback   = CfgAddrBits'(1);
    localparam logic [CfgAddrBits-1:0] AddrHactive = CfgAddrBits'(2);
    localparam logic [CfgAddrBits-1:0] AddrHfront  = CfgAddrBits'(3);
    localparam logic [CfgAddrBits-1:0] AddrVsync   = CfgAddrBits'(4);
    localparam logic [CfgAddrBits-1:0] AddrVback   = CfgAddrBits'(5);
    localparam logic [CfgAddrBits-1:0] AddrVactive = CfgAddrBits'(6);
    localparam logic [CfgAddrBits-1:0] AddrVfront  = CfgAddrBits'(7);
`ifdef VIDEO_TIMING_POLARITY_EN
    localparam logic [CfgAddrBits-1:0] AddrPolarity = CfgAddrBits'(8);
`endif

    // 1280x720p60 defaults
    localparam int unsigned DefHsync   = 40;
    localparam int unsigned DefHback   = 220;
    localparam int unsigned DefHactive = 1280;
    localparam int unsigned DefHfront  = 110;
    localparam int unsigned DefVsync   = 5;
    localparam int unsigned DefVback   = 20;
    localparam int unsigned DefVactive = 720;
    localparam int unsigned DefVfront  = 5;

    localparam logic [TotalBits-1:0] TotalLimit = TotalBits'(1) << CounterBits;

    typedef struct packed {
        logic [CounterBits-1:0] hsync;
        logic [CounterBits-1:0] hback;
        logic [CounterBits-1:0] hactive;
        logic [CounterBits-1:0] hfront;
        logic [CounterBits-1:0] vsync;
        logic [CounterBits-1:0] vback;
        logic [CounterBits-1:0] vactive;
        logic [CounterBits-1:0] vfront;
    } timing_t;

    function automatic logic [TotalBits-1:0] htotal(timing_t t);
        return TotalBits'(t.hsync) + TotalBits'(t.hback) + TotalBits'(t.hactive)
             + TotalBits'(t.hfront);
    endfunction

    function automatic logic [TotalBits-1:0] vtotal(timing_t t);
        return TotalBits'(t.vsync) + TotalBits'(t.vback) + TotalBits'(t.vactive)
             + TotalBits'(t.vfront);
    endfunction

    function automatic logic timing_valid(timing_t t);
        return (t.hsync != '0) && (t.hactive != '0) && (t.vsync != '0) && (t.vactive != '0)
            && (htotal(t) <= TotalLimit) && (vtotal(t) <= TotalLimit);
    endfunction

endpackage

// File: rtl/video_timing_controller_if.sv
// Control-register bus of the video timing controller: shadow writes plus commit handshake.
interface video_timing_controller_if;
    import video_timing_pkg::*;

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CfgAddrBits-1:0] cfg_addr;
    logic [CounterBits-1:0] cfg_data;
    logic                   commit;
    logic                   commit_pending;
    logic                   cfg_error;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, commit,
        input  cfg_ready, commit_pending, cfg_error
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, commit,
        output cfg_ready, commit_pending, cfg_error
    );

endinterface

// File: rtl/video_timing_counter.sv
// H/V raster counters for one active timing set, with registered sync/de/coordinate outputs.
module video_timing_counter
    import video_timing_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  timing_t                timing_i,
    output logic                   active_o,
    output logic                   frame_end_o,
    output logic                   de_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [CounterBits-1:0] pixel_x_o,
    output logic [CounterBits-1:0] pixel_y_o,
    output logic                   frame_start_o,
    output logic                   line_start_o
);

    typedef enum logic [0:0] {StStopped, StRunning} state_e;

    state_e                 state_q;
    logic [CounterBits-1:0] h_q, v_q;
    logic                   de_q, hsync_q, vsync_q, frame_start_q, line_start_q;
    logic [CounterBits-1:0] pixel_x_q, pixel_y_q;

    logic [TotalBits-1:0] htotal_w, vtotal_w, h_ext, v_ext;
    logic [TotalBits-1:0] h_act_lo, h_act_hi, v_act_lo, v_act_hi;
    logic                 h_last, v_last, de_w, active;

    always_comb begin
        htotal_w = htotal(timing_i);
        vtotal_w = vtotal(timing_i);
        h_ext    = TotalBits'(h_q);
        v_ext    = TotalBits'(v_q);
        // >= rather than == so a counter can never run past the end of a line or frame
        h_last   = h_ext >= (htotal_w - TotalBits'(1));
        v_last   = v_ext >= (vtotal_w - TotalBits'(1));
        h_act_lo = TotalBits'(timing_i.hsync) + TotalBits'(timing_i.hback);
        h_act_hi = h_act_lo + TotalBits'(timing_i.hactive);
        v_act_lo = TotalBits'(timing_i.vsync) + TotalBits'(timing_i.vback);
        v_act_hi = v_act_lo + TotalBits'(timing_i.vactive);
        de_w     = (h_ext >= h_act_lo) && (h_ext < h_act_hi)
                && (v_ext >= v_act_lo) && (v_ext < v_act_hi);
    end

    // The current counter position is emitted only while running and still enabled.
    assign active      = (state_q == StRunning) && enable_i;
    assign active_o    = active;
    assign frame_end_o = active && h_last && v_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StStopped;
            h_q           <= '0;
            v_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            if (!enable_i) begin
                state_q <= StStopped;
                h_q     <= '0;
                v_q     <= '0;
            end else if (state_q == StStopped) begin
                state_q <= StRunning;
            end else if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end

            de_q          <= active && de_w;
            hsync_q       <= active && (h_q < timing_i.hsync);
            vsync_q       <= active && (v_q < timing_i.vsync);
            pixel_x_q     <= (active && de_w) ? h_q - timing_i.hsync - timing_i.hback : '0;
            pixel_y_q     <= (active && de_w) ? v_q - timing_i.vsync - timing_i.vback : '0;
            frame_start_q <= active && (h_q == '0) && (v_q == '0);
            line_start_q  <= active && (h_q == '0);
        end
    end

    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign frame_start_o = frame_start_q;
    assign line_start_o  = line_start_q;

endmodule

// File: rtl/video_timing_controller.sv
// Runtime-configurable video timing generator: shadow/active timing registers and commit FSM.
// Define VIDEO_TIMING_POLARITY_EN to add a committed per-sync polarity field at address 8.
module video_timing_controller
    import video_timing_pkg::*;
#(
    parameter int unsigned COUNTER_BITS = CounterBits,
    parameter int unsigned DEF_HSYNC    = DefHsync,
    parameter int unsigned DEF_HBACK    = DefHback,
    parameter int unsigned DEF_HACTIVE  = DefHactive,
    parameter int unsigned DEF_HFRONT   = DefHfront,
    parameter int unsigned DEF_VSYNC    = DefVsync,
    parameter int unsigned DEF_VBACK    = DefVback,
    parameter int unsigned DEF_VACTIVE  = DefVactive,
    parameter int unsigned DEF_VFRONT   = DefVfront
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable_i,
    video_timing_controller_if.slave cfg_if,
    output logic                    video_de_o,
    output logic                    video_hsync_o,
    output logic                    video_vsync_o,
    output logic [COUNTER_BITS-1:0] pixel_x_o,
    output logic [COUNTER_BITS-1:0] pixel_y_o,
    output logic                    frame_start_o,
    output logic                    line_start_o
);

    if (COUNTER_BITS != CounterBits) begin : g_width_check
        $error("COUNTER_BITS must equal video_timing_pkg::CounterBits");
    end

    localparam timing_t DefTiming = '{
        hsync:   CounterBits'(DEF_HSYNC),
        hback:   CounterBits'(DEF_HBACK),
        hactive: CounterBits'(DEF_HACTIVE),
        hfront:  CounterBits'(DEF_HFRONT),
        vsync:   CounterBits'(DEF_VSYNC),
        vback:   CounterBits'(DEF_VBACK),
        vactive: CounterBits'(DEF_VACTIVE),
        vfront:  CounterBits'(DEF_VFRONT)
    };

    typedef enum logic [0:0] {StIdle, StPending} commit_state_e;

    commit_state_e state_q;
    timing_t       shadow_q, shadow_d, active_q;
    logic          cfg_error_q;
    logic          cfg_wr, shadow_ok, boundary;
    logic          cnt_active, cnt_frame_end, cnt_hsync, cnt_vsync;
`ifdef VIDEO_TIMING_POLARITY_EN
    logic [1:0]    pol_shadow_q, pol_shadow_d, pol_active_q;
`endif

    assign cfg_if.cfg_ready      = (state_q == StIdle);
    assign cfg_if.commit_pending = (state_q == StPending);
    assign cfg_if.cfg_error      = cfg_error_q;
    assign cfg_wr                = cfg_if.cfg_valid && cfg_if.cfg_ready;

    always_comb begin
        shadow_d = shadow_q;
`ifdef VIDEO_TIMING_POLARITY_EN
        pol_shadow_d = pol_shadow_q;
`endif
        if (cfg_wr) begin
            case (cfg_if.cfg_addr)
                AddrHsync:    shadow_d.hsync   = cfg_if.cfg_data;
                AddrHback:    shadow_d.hback   = cfg_if.cfg_data;
                AddrHactive:  shadow_d.hactive = cfg_if.cfg_data;
                AddrHfront:   shadow_d.hfront  = cfg_if.cfg_data;
                AddrVsync:    shadow_d.vsync   = cfg_if.cfg_data;
                AddrVback:    shadow_d.vback   = cfg_if.cfg_data;
                AddrVactive:  shadow_d.vactive = cfg_if.cfg_data;
                AddrVfront:   shadow_d.vfront  = cfg_if.cfg_data;
`ifdef VIDEO_TIMING_POLARITY_EN
                AddrPolarity: pol_shadow_d     = cfg_if.cfg_data[1:0];
`endif
                default: ;
            endcase
        end
    end

    // Validation sees a write landing in the same cycle as the commit.
    assign shadow_ok = timing_valid(shadow_d);
    // Safe to swap timing when the raster is not advancing or is on its final pixel.
    assign boundary  = !cnt_active || cnt_frame_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q     <= DefTiming;
`ifdef VIDEO_TIMING_POLARITY_EN
            pol_shadow_q <= 2'b00;
`endif
        end else begin
            shadow_q     <= shadow_d;
`ifdef VIDEO_TIMING_POLARITY_EN
            pol_shadow_q <= pol_shadow_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cfg_error_q  <= 1'b0;
            active_q     <= DefTiming;
`ifdef VIDEO_TIMING_POLARITY_EN
            pol_active_q <= 2'b00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_if.commit) begin
                        if (shadow_ok) begin
                            cfg_error_q <= 1'b0;
                            if (boundary) begin
                                active_q     <= shadow_d;
`ifdef VIDEO_TIMING_POLARITY_EN
                                pol_active_q <= pol_shadow_d;
`endif
                            end else begin
                                state_q <= StPending;
                            end
                        end else begin
                            cfg_error_q <= 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (boundary) begin
                        active_q     <= shadow_q;
`ifdef VIDEO_TIMING_POLARITY_EN
                        pol_active_q <= pol_shadow_q;
`endif
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    video_timing_counter u_counter (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (enable_i),
        .timing_i      (active_q),
        .active_o      (cnt_active),
        .frame_end_o   (cnt_frame_end),
        .de_o          (video_de_o),
        .hsync_o       (cnt_hsync),
        .vsync_o       (cnt_vsync),
        .pixel_x_o     (pixel_x_o),
        .pixel_y_o     (pixel_y_o),
        .frame_start_o (frame_start_o),
        .line_start_o  (line_start_o)
    );

`ifdef VIDEO_TIMING_POLARITY_EN
    assign video_hsync_o = cnt_hsync ^ pol_active_q[0];
    assign video_vsync_o = cnt_vsync ^ pol_active_q[1];
`else
    assign video_hsync_o = cnt_hsync;
    assign video_vsync_o = cnt_vsync;
`endif

endmodule

// File: tb/tb_video_timing_controller.sv
// Randomised scoreboard bench: a raster-index reference model predicts every output cycle.
module tb_video_timing_controller;
    import video_timing_pkg::*;

    typedef struct packed {
        logic                   de;
        logic                   hs;
        logic                   vs;
        logic                   fs;
        logic                   ls;
        logic [CounterBits-1:0] px;
        logic [CounterBits-1:0] py;
        logic                   rdy;
        logic                   pend;
        logic                   err;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic de, hs, vs, fs, ls;
    logic [CounterBits-1:0] px, py;

    video_timing_controller_if cfg_if ();

    video_timing_controller dut (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (enable),
        .cfg_if        (cfg_if),
        .video_de_o    (de),
        .video_hsync_o (hs),
        .video_vsync_o (vs),
        .pixel_x_o     (px),
        .pixel_y_o     (py),
        .frame_start_o (fs),
        .line_start_o  (ls)
    );

    always #5 clock = ~clock;

`ifdef VIDEO_TIMING_POLARITY_EN
    localparam int NumAddr = 9;
`else
    localparam int NumAddr = 8;
`endif

    int defs[8] = '{40, 220, 1280, 110, 5, 20, 720, 5};
    int ta[8]   = '{3, 2, 8, 2, 1, 2, 5, 1};
    int tb2[8]  = '{2, 1, 6, 3, 2, 1, 4, 2};

    // Reference model: position is a linear pixel index into the frame.
    int sh[8], ac[8];
    int sh_pol, ac_pol;
    bit m_run, m_pend, m_err;
    int m_pos;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 0;

    function automatic bit valid_t(input int t[8]);
        int htot, vtot;
        htot = t[0] + t[1] + t[2] + t[3];
        vtot = t[4] + t[5] + t[6] + t[7];
        return (t[0] != 0) && (t[2] != 0) && (t[4] != 0) && (t[6] != 0)
            && (htot <= (1 << CounterBits)) && (vtot <= (1 << CounterBits));
    endfunction

    always @(posedge clock) begin
        obs_t e;
        int   ht, vt, h, v, a;
        bit   act, last, bnd;
        e = '0;
        if (reset) begin
            sh = defs;
            ac = defs;
            sh_pol = 0;
            ac_pol = 0;
            m_run = 0;
            m_pos = 0;
            m_pend = 0;
            m_err = 0;
        end else begin
            ht  = ac[0] + ac[1] + ac[2] + ac[3];
            vt  = ac[4] + ac[5] + ac[6] + ac[7];
            act = m_run && enable;
            if (act) begin
                h = m_pos % ht;
                v = m_pos / ht;
                e.hs = (h < ac[0]);
                e.vs = (v < ac[4]);
                e.de = (h >= ac[0] + ac[1]) && (h < ac[0] + ac[1] + ac[2])
                    && (v >= ac[4] + ac[5]) && (v < ac[4] + ac[5] + ac[6]);
                if (e.de) begin
                    e.px = CounterBits'(h - ac[0] - ac[1]);
                    e.py = CounterBits'(v - ac[4] - ac[5]);
                end
                e.fs = (m_pos == 0);
                e.ls = (h == 0);
            end
            if (cfg_if.cfg_valid && !m_pend) begin
                a = int'(cfg_if.cfg_addr);
                if (a < 8) sh[a] = int'(cfg_if.cfg_data);
                else if (a == 8) sh_pol = int'(cfg_if.cfg_data) & 3;
            end
            last = act && (m_pos == ht * vt - 1);
            bnd  = !act || last;
            if (m_pend) begin
                if (bnd) begin
                    ac = sh;
                    ac_pol = sh_pol;
                    m_pend = 0;
                end
            end else if (cfg_if.commit) begin
                if (valid_t(sh)) begin
                    m_err = 0;
                    if (bnd) begin
                        ac = sh;
                        ac_pol = sh_pol;
                    end else begin
                        m_pend = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (!enable) begin
                m_run = 0;
                m_pos = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_pos = 0;
            end else begin
                m_pos = last ? 0 : m_pos + 1;
            end
        end
`ifdef VIDEO_TIMING_POLARITY_EN
        e.hs = e.hs ^ ac_pol[0];
        e.vs = e.vs ^ ac_pol[1];
`endif
        e.pend = m_pend;
        e.err  = m_err;
        e.rdy  = !m_pend;
        exp_q.push_back(e);
    end

    always @(negedge clock) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{de: de, hs: hs, vs: vs, fs: fs, ls: ls, px: px, py: py,
                  rdy: cfg_if.cfg_ready, pend: cfg_if.commit_pending, err: cfg_if.cfg_error};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got de=%b hs=%b vs=%b fs=%b ls=%b x=%0d y=%0d rdy=%b pend=%b err=%b | want de=%b hs=%b vs=%b fs=%b ls=%b x=%0d y=%0d rdy=%b pend=%b err=%b",
                         $time, g.de, g.hs, g.vs, g.fs, g.ls, g.px, g.py, g.rdy, g.pend, g.err,
                         e.de, e.hs, e.vs, e.fs, e.ls, e.px, e.py, e.rdy, e.pend, e.err);
            end
        end
    end

    initial begin
        #20_000_000;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout @%0t: stimulus did not finish", $time);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int a, input int d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = CfgAddrBits'(a);
        cfg_if.cfg_data  = CounterBits'(d);
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic write_timing(input int t[8]);
        for (int i = 0; i < 8; i++) wr(i, t[i]);
    endtask

    task automatic commit_pulse();
        cfg_if.commit = 1'b1;
        tick();
        cfg_if.commit = 1'b0;
    endtask

    initial begin
        int r;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_data  = '0;
        cfg_if.commit    = 1'b0;
        run(3);
        n_cmp++;
        if ({de, hs, vs, fs, ls} !== 5'b0 || px !== '0 || py !== '0
            || cfg_if.cfg_ready !== 1'b1 || cfg_if.commit_pending !== 1'b0
            || cfg_if.cfg_error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state @%0t: de=%b hs=%b vs=%b fs=%b ls=%b x=%0d y=%0d rdy=%b pend=%b err=%b",
                     $time, de, hs, vs, fs, ls, px, py, cfg_if.cfg_ready,
                     cfg_if.commit_pending, cfg_if.cfg_error);
        end
        reset = 1'b0;
        run(2);

        // default 720p raster: first lines, hsync width, line_start
        enable = 1'b1;
        run(3400);

        // commit while stopped applies immediately
        enable = 1'b0;
        run(2);
        write_timing(ta);
        commit_pulse();
        run(2);
        enable = 1'b1;
        run(3 * 135 + 20);

        // mid-frame commit stays pending; writes during pending are dropped
        write_timing(tb2);
        run(37);
        commit_pulse();
        run(10);
        wr(2, 9);
        commit_pulse();
        run(300);

        // rejected commit, then write+commit in the same cycle
        wr(2, 0);
        commit_pulse();
        run(5);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = CfgAddrBits'(2);
        cfg_if.cfg_data  = CounterBits'(7);
        cfg_if.commit    = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.commit    = 1'b0;
        run(200);

        // HTOTAL overflow: 40+220+4095+110 > 4096
        wr(0, 40);
        wr(1, 220);
        wr(2, 4095);
        wr(3, 110);
        commit_pulse();
        run(5);
        write_timing(ta);
        commit_pulse();
        run(300);

        // disable mid-frame and restart
        run(57);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(200);

        repeat (20000) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            cfg_if.cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_if.cfg_addr  = CfgAddrBits'($urandom_range(0, NumAddr - 1));
            r = int'($urandom_range(0, 63));
            cfg_if.cfg_data  = (r == 0) ? CounterBits'(0) :
                               (r == 1) ? CounterBits'(4000) :
                               CounterBits'($urandom_range(1, 6));
            cfg_if.commit    = ($urandom_range(0, 99) == 0);
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        cfg_if.commit    = 1'b0;
        run(5);
        @(negedge clock);
        #1;
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_controller.md
Name: video_timing_controller

Overview:
- Runtime-configurable video timing sequencer for the video output path.
- Holds shadow and active timing registers and generates hsync, vsync, de and pixel coordinates.
- Applies new timing only at frame boundaries, so a mode change never produces a torn frame.
- Sits between the control-register bus and the pixel sources (pattern generators, framebuffer readers), which consume its x/y/de/sync outputs.

Parameters:
- COUNTER_BITS, 12, width of h/v counters, coordinates and config fields.
- DEF_HSYNC, 40, reset value of the H sync width.
- DEF_HBACK, 220, reset value of the H back porch.
- DEF_HACTIVE, 1280, reset value of the H active width.
- DEF_HFRONT, 110, reset value of the H front porch.
- DEF_VSYNC, 5, reset value of the V sync width.
- DEF_VBACK, 20, reset value of the V back porch.
- DEF_VACTIVE, 720, reset value of the V active height.
- DEF_VFRONT, 5, reset value of the V front porch.

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  run timing; when 0, counters are held at 0
- cfg_valid  in  1  shadow register write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_addr  in  3  field select: 0 HSYNC, 1 HBACK, 2 HACTIVE, 3 HFRONT, 4 VSYNC, 5 VBACK, 6 VACTIVE, 7 VFRONT
- cfg_data  in  COUNTER_BITS  field value
- commit  in  1  single-cycle pulse: copy shadow to active at the next frame boundary
- commit_pending  out  1  commit accepted, not yet applied
- cfg_error  out  1  sticky; set when a commit is rejected, cleared by reset or by an accepted commit
- video_de  out  1  active-area flag
- video_hsync  out  1  H sync
- video_vsync  out  1  V sync
- pixel_x  out  COUNTER_BITS  active-area x; 0 outside the active area
- pixel_y  out  COUNTER_BITS  active-area y; 0 outside the active area
- frame_start  out  1  one-cycle pulse aligned with h=0, v=0
- line_start  out  1  one-cycle pulse aligned with every h=0

Behaviour:
- Reset: shadow and active registers load the DEF_* values; hcounter = vcounter = 0; state STOPPED.
- Reset values of outputs: all outputs 0 except cfg_ready = 1.
- Reset mid-operation discards any pending commit.
- Totals: HTOTAL = sum of the four H fields; VTOTAL = sum of the four V fields; both computed at COUNTER_BITS+2 width.
- State STOPPED (enable=0):
  - Counters are held at 0 and all video outputs are driven 0.
  - A commit applies on the next cycle.
- STOPPED → RUNNING when enable=1:
  - The first cycle has h=0, v=0.
  - frame_start and line_start assert on the registered output of that cycle.
- State RUNNING:
  - hcounter increments every cycle and wraps at HTOTAL-1.
  - vcounter increments on each h wrap and wraps at VTOTAL-1.
- RUNNING → STOPPED when enable=0 mid-frame: counters clear and outputs go 0 on the next cycle. Any pending commit is applied on that transition.
- Output timing: all outputs are registered with 1-cycle latency from the counters.
  - video_hsync = h < HSYNC.
  - video_vsync = v < VSYNC.
  - video_de = active region in both h and v.
  - pixel_x = h-(HSYNC+HBACK) and pixel_y = v-(VSYNC+VBACK) while de; 0 otherwise.
- Config writes: cfg_ready = !commit_pending. Writes update shadow registers only. Writes to the active timing never happen mid-frame.
- Commit acceptance: a commit is accepted only when the shadow contents pass validation:
  - HSYNC, HACTIVE, VSYNC and VACTIVE are all nonzero;
  - HTOTAL ≤ 2^COUNTER_BITS;
  - VTOTAL ≤ 2^COUNTER_BITS.
- Failed commit: cfg_error=1, commit_pending stays 0, and the active timing is unchanged.
- Accepted commit: commit_pending=1.
- Commit apply: when h=HTOTAL-1 and v=VTOTAL-1, active ← shadow and commit_pending ← 0. The next cycle starts frame 0 of the new timing.
- Commit while commit_pending=1: ignored; no error is raised.
- Simultaneous cfg write and commit: the write is accepted (cfg_ready was 1), and validation uses the post-write shadow value.

Optional Feature:
- Macro: VIDEO_TIMING_POLARITY_EN.
- With the macro: cfg_addr widens to 4. Address 8 writes bit0 = hsync polarity and bit1 = vsync polarity (1 = active-low) into shadow. Polarity is applied at commit like the other fields, and the registered sync outputs are XORed with it. Reset value of both polarity bits is 0. In STOPPED, the sync outputs idle at their inactive level.
- Without the macro: cfg_addr is 3 bits and syncs are active-high only.

Decomposition:
- Package video_timing_pkg holds:
  - the timing_t struct (eight fields of COUNTER_BITS);
  - cfg address localparams;
  - the 720p default localparams;
  - a timing_valid() function.
- One sub-module, video_timing_counter: takes active timing_t and enable; produces h/v counters, frame_end and the registered sync/de/coordinate outputs.
- The top level holds the shadow/active registers, commit FSM and validation.

Test Plan:
- Default run: reset, enable=1 → HTOTAL=1650 and VTOTAL=750. hsync high for 40 cycles per line; de first asserts at h=260, v=25 with pixel_x=0. frame_start period is 1237500 cycles.
- Mid-frame commit: write 640x480 timing (16/48/640/96? as HSYNC=96, HBACK=48, HACTIVE=640, HFRONT=16; VSYNC=2, VBACK=33, VACTIVE=480, VFRONT=10), then commit at v=100 → commit_pending=1 and cfg_ready=0 until the 720p frame ends. The next frame has HTOTAL=800 and VTOTAL=525.
- Invalid commit: write HACTIVE=0, then commit → cfg_error=1, commit_pending=0, timing unchanged. Write HACTIVE=640 and commit → cfg_error clears.
- Overflow: set HACTIVE=4095 with default porches, then commit → HTOTAL=4465 > 4096, so cfg_error=1.
- Disable mid-frame: enable=0 at h=500, v=300 → all outputs 0 next cycle. Re-enable → frame_start asserts 1 cycle later.
- Stopped commit: with enable=0, commit valid timing → commit_pending=0 after 1 cycle. New totals are visible on the first enabled frame.
